framebuffer_pingpong: RTL and testbench

FRAMEBUFFER_PINGPONG -- requirements
Module: framebuffer_pingpong

---
 rtl/framebuffer_pingpong.sv | 105 ++++++++++
 tb/tb_framebuffer_pingpong.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_pingpong.sv
// framebuffer_pingpong: double-buffered frame store; the writer fills the back bank and
// the reader's rd_sof publishes a completed frame by swapping banks.
module framebuffer_pingpong #(
    parameter int DATA_W = 8,
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = $clog2(H_RES*V_RES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic              wr_sof,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_frame_done,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_sof,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_ready,
    output logic [7:0]        drop_cnt,
    output logic              err_short
);
    localparam int PIXELS = H_RES*V_RES;
    localparam logic [ADDR_W:0] BANK_OFS = (ADDR_W+1)'(PIXELS);

    typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

    logic [DATA_W-1:0] mem [2*PIXELS];
    state_t            state, state_nx;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_nx, wr_addr;
    logic [ADDR_W:0]   wr_idx, rd_idx;
    logic [7:0]        drop_nx;
    logic              front, pending, we, last, err_nx, swap, rd_bank, rd_in_range;

    always_comb begin
        state_nx  = state;
        wr_ptr_nx = wr_ptr;
        wr_addr   = wr_ptr;
        we        = 1'b0;
        err_nx    = err_short;
        drop_nx   = drop_cnt;
        if (state == WRITE) begin
            if (wr_valid) begin
                we      = 1'b1;
                wr_addr = wr_sof ? '0 : wr_ptr;
                err_nx  = err_short | wr_sof;
            end
        end else if (wr_valid && wr_sof) begin
            // A frame still awaiting publication cannot be overwritten, so the new one is dropped
            if (pending) begin
                state_nx = DROP;
                drop_nx  = drop_cnt + 8'(drop_cnt != 8'hFF);
            end else begin
                we      = 1'b1;
                wr_addr = '0;
            end
        end
        last = we && (wr_addr == ADDR_W'(PIXELS-1));
        if (we) begin
            state_nx  = last ? IDLE : WRITE;
            wr_ptr_nx = last ? '0 : wr_addr + ADDR_W'(1);
        end
    end

    assign wr_idx      = {1'b0, wr_addr} + (front ? '0 : BANK_OFS);
    assign swap        = rd_sof & pending;
    assign rd_bank     = swap ? ~front : front;
    assign rd_in_range = {1'b0, rd_addr} < BANK_OFS;
    assign rd_idx      = rd_in_range ? {1'b0, rd_addr} + (rd_bank ? BANK_OFS : '0) : '0;

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            front         <= 1'b0;
            pending       <= 1'b0;
            frame_ready   <= 1'b0;
            wr_frame_done <= 1'b0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            drop_cnt      <= '0;
            err_short     <= 1'b0;
        end else begin
            state         <= state_nx;
            wr_ptr        <= wr_ptr_nx;
            drop_cnt      <= drop_nx;
            err_short     <= err_nx;
            wr_frame_done <= last;
            // Completion never coincides with a swap: writing only proceeds while nothing is pending
            pending       <= last | (pending & ~rd_sof);
            if (swap) begin
                front       <= ~front;
                frame_ready <= 1'b1;
            end
            rd_valid <= rd_en;
            rd_data  <= (rd_en && frame_ready && rd_in_range) ? mem[rd_idx] : '0;
        end
    end
endmodule

// File: tb/tb_framebuffer_pingpong.sv
// tb_framebuffer_pingpong: vector table, directed corner sequences and random traffic
// checked against a frame-level reference model.
module tb_framebuffer_pingpong;
    localparam int P  = 8;
    localparam int AW = 4;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          wr_valid = 1'b0, wr_sof = 1'b0, rd_en = 1'b0, rd_sof = 1'b0;
    logic [7:0]    wr_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic          wr_frame_done, rd_valid, frame_ready, err_short;
    logic [7:0]    rd_data, drop_cnt;

    framebuffer_pingpong #(.DATA_W(8), .H_RES(4), .V_RES(2), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_sof(wr_sof), .wr_data(wr_data),
        .wr_frame_done(wr_frame_done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_sof(rd_sof),
        .rd_valid(rd_valid), .rd_data(rd_data), .frame_ready(frame_ready),
        .drop_cnt(drop_cnt), .err_short(err_short)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a queue of pixels that lands in the back bank once complete
    logic [7:0] m_bank [2][P];
    logic [7:0] m_cur [$];
    logic [7:0] m_rdata;
    int m_front, m_pending, m_ready, m_active, m_drop, m_err, m_done, m_rvalid;

    task automatic model_reset();
        m_cur.delete();
        m_front = 0; m_pending = 0; m_ready = 0; m_active = 0;
        m_drop = 0; m_err = 0; m_done = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    task automatic model_edge();
        int swap, rb;
        swap = (rd_sof && m_pending != 0) ? 1 : 0;
        rb = swap ? 1 - m_front : m_front;
        m_rvalid = rd_en ? 1 : 0;
        m_rdata = '0;
        if (rd_en && m_ready != 0 && rd_addr < P)
            m_rdata = m_bank[rb][rd_addr];
        m_done = 0;
        if (wr_valid) begin
            if (m_active != 0) begin
                if (wr_sof) begin
                    m_err = 1;
                    m_cur.delete();
                end
                m_cur.push_back(wr_data);
            end else if (wr_sof) begin
                if (m_pending != 0) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    m_cur.delete();
                    m_cur.push_back(wr_data);
                    m_active = 1;
                end
            end
            if (m_active != 0 && m_cur.size() == P) begin
                for (int i = 0; i < P; i++) m_bank[1-m_front][i] = m_cur[i];
                m_active = 0; m_pending = 1; m_done = 1;
            end
        end
        if (swap != 0) begin
            m_front = 1 - m_front; m_pending = 0; m_ready = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("wr_frame_done", wr_frame_done, m_done);
        check("frame_ready", frame_ready, m_ready);
        check("drop_cnt", drop_cnt, m_drop);
        check("err_short", err_short, m_err);
        check("rd_valid", rd_valid, m_rvalid);
        if (m_rvalid != 0) check("rd_data", rd_data, m_rdata);
    endtask

    task automatic drive(input logic wv, input logic ws, input logic [7:0] wd,
                         input logic re, input logic [AW-1:0] ra, input logic rs);
        wr_valid = wv; wr_sof = ws; wr_data = wd; rd_en = re; rd_addr = ra; rd_sof = rs;
        step();
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 1'b0, '0, 1'b0);
    endtask

    task automatic wr_frame(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) drive(1'b1, i == 0, base + 8'(i), 1'b0, '0, 1'b0);
    endtask

    task automatic pulse_sof();
        drive(1'b0, 1'b0, 8'h00, 1'b0, '0, 1'b1);
    endtask

    task automatic rd_frame(input logic [7:0] base);
        for (int i = 0; i < P; i++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1, AW'(i), 1'b0);
            check("rd_frame_data", rd_data, base + 8'(i));
        end
        idle();
    endtask

    task automatic do_reset();
        wr_valid = 1'b0; wr_sof = 1'b0; rd_en = 1'b0; rd_sof = 1'b0;
        rst_n = 1'b0;
        #2;
        check("rst_wr_frame_done", wr_frame_done, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_frame_ready", frame_ready, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_err_short", err_short, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic wv, ws; logic [7:0] wd; logic re; logic [AW-1:0] ra; logic rs;
        logic e_done, e_ready, e_rvalid; logic [7:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(input logic wv, input logic ws, input logic [7:0] wd,
                                input logic re, input logic [AW-1:0] ra, input logic rs,
                                input logic e_done, input logic e_ready,
                                input logic e_rvalid, input logic [7:0] e_rdata);
        vec_t v;
        v.wv = wv; v.ws = ws; v.wd = wd; v.re = re; v.ra = ra; v.rs = rs;
        v.e_done = e_done; v.e_ready = e_ready; v.e_rvalid = e_rvalid; v.e_rdata = e_rdata;
        return v;
    endfunction

    vec_t tbl [20];

    initial begin
        tbl[0] = mk(1'b0, 1'b0, 8'h00, 1'b1, AW'(3), 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 8; i++)
            tbl[1+i] = mk(1'b1, i == 0, 8'h10 + 8'(i), 1'b0, '0, 1'b0, i == 7, 1'b0, 1'b0, 8'h00);
        tbl[9] = mk(1'b0, 1'b0, 8'h00, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++)
            tbl[10+i] = mk(1'b0, 1'b0, 8'h00, 1'b1, AW'(i), 1'b0, 1'b0, 1'b1, 1'b1, 8'h10 + 8'(i));
        tbl[18] = mk(1'b0, 1'b0, 8'h00, 1'b1, AW'(9), 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        tbl[19] = mk(1'b0, 1'b0, 8'h00, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].wv, tbl[i].ws, tbl[i].wd, tbl[i].re, tbl[i].ra, tbl[i].rs);
            check("tbl_done", wr_frame_done, tbl[i].e_done);
            check("tbl_ready", frame_ready, tbl[i].e_ready);
            check("tbl_rd_valid", rd_valid, tbl[i].e_rvalid);
            if (tbl[i].e_rvalid) check("tbl_rd_data", rd_data, tbl[i].e_rdata);
        end

        // Published-frame protection: the second frame is dropped while the first is pending
        wr_frame(8'h20, 8);
        wr_frame(8'h30, 8);
        check("drop_one", drop_cnt, 1);
        pulse_sof();
        rd_frame(8'h20);

        // Restart mid-frame
        wr_frame(8'h40, 3);
        wr_frame(8'h50, 8);
        check("err_short_set", err_short, 1);
        pulse_sof();
        rd_frame(8'h50);

        // Completion coincident with rd_sof publishes only at the following rd_sof
        wr_frame(8'h60, 7);
        drive(1'b1, 1'b0, 8'h67, 1'b0, '0, 1'b1);
        check("late_done", wr_frame_done, 1);
        drive(1'b0, 1'b0, 8'h00, 1'b1, AW'(0), 1'b0);
        check("no_swap_data", rd_data, 8'h50);
        pulse_sof();
        rd_frame(8'h60);

        // Reset mid-frame, stray pixels without sof are ignored
        wr_frame(8'h70, 5);
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'hEE, 1'b0, '0, 1'b0);
        wr_frame(8'h80, 8);
        pulse_sof();
        check("ready_after_reset", frame_ready, 1);
        rd_frame(8'h80);

        // Drop counter saturation
        wr_frame(8'h90, 8);
        for (int i = 0; i < 260; i++) drive(1'b1, 1'b1, 8'hAA, 1'b0, '0, 1'b0);
        check("drop_saturate", drop_cnt, 255);
        pulse_sof();

        for (int i = 0; i < 3000; i++)
            drive(($urandom % 4) != 0, ($urandom % 16) == 0, 8'($urandom),
                  ($urandom % 2) != 0, AW'($urandom_range(0, 9)), ($urandom % 20) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
